// File: rtl/agp32_mem_bridge.sv
// Registered bridge between the agp32 processor memory port and the memory subsystem.
// Handles one request at a time, with address alignment, a response timeout and error counting.
module agp32_mem_bridge #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ALIGN_BITS     = 2,
  parameter int unsigned STRICT_ALIGN   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ERRCNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            cpu_command,
  input  logic [ADDR_W-1:0]     cpu_inst_addr,
  input  logic [ADDR_W-1:0]     cpu_data_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [DATA_W/8-1:0]   cpu_wstrb,
  output logic                  cpu_ready,
  output logic [1:0]            cpu_error,
  output logic [DATA_W-1:0]     cpu_inst_rdata,
  output logic [DATA_W-1:0]     cpu_data_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_accept,
  output logic [2:0]            mem_command,
  output logic [ADDR_W-1:0]     mem_inst_addr,
  output logic [ADDR_W-1:0]     mem_data_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic                  mem_resp_valid,
  input  logic                  mem_resp_error,
  input  logic [DATA_W-1:0]     mem_inst_rdata,
  input  logic [DATA_W-1:0]     mem_data_rdata,
  output logic [ERRCNT_W-1:0]   err_count
);

  localparam int unsigned StrbW  = DATA_W / 8;
  localparam int unsigned TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LsbMask   = (ADDR_W'(1) << ALIGN_BITS) - ADDR_W'(1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e              state_q, state_d;
  logic [2:0]          cmd_q, cmd_d;
  logic [ADDR_W-1:0]   iaddr_q, iaddr_d;
  logic [ADDR_W-1:0]   daddr_q, daddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [StrbW-1:0]    wstrb_q, wstrb_d;
  logic [1:0]          error_q, error_d;
  logic [DATA_W-1:0]   inst_q, inst_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;
  logic [TimerW-1:0]   timer_q, timer_d;

  logic cmd_valid, cmd_write, misaligned, want_inst, want_data;

  assign cmd_valid  = (cpu_command >= 3'd1) && (cpu_command <= 3'd5);
  assign cmd_write  = (cpu_command == 3'd3) || (cpu_command == 3'd5);
  assign misaligned = (STRICT_ALIGN != 0) && cmd_write && ((cpu_data_addr & LsbMask) != '0);
  assign want_inst  = (cmd_q == 3'd1) || (cmd_q == 3'd4) || (cmd_q == 3'd5);
  assign want_data  = (cmd_q == 3'd2) || (cmd_q == 3'd4);

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    iaddr_d  = iaddr_q;
    daddr_d  = daddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    error_d  = error_q;
    inst_d   = inst_q;
    data_d   = data_q;
    errcnt_d = errcnt_q;
    timer_d  = timer_q;
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          cmd_d   = cpu_command;
          iaddr_d = cpu_inst_addr & ~LsbMask;
          daddr_d = cpu_data_addr & ~LsbMask;
          wdata_d = cpu_wdata;
          wstrb_d = cpu_wstrb;
          // Misaligned writes complete immediately without touching memory.
          if (misaligned) begin
            error_d = 2'b11;
            state_d = StDone;
          end else begin
            error_d = 2'b00;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (mem_req_accept) begin
          timer_d = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        timer_d = timer_q + 1'b1;
        // A response on the timeout edge still counts as a normal completion.
        if (mem_resp_valid) begin
          if (want_inst) inst_d = mem_inst_rdata;
          if (want_data) data_d = mem_data_rdata;
          error_d = mem_resp_error ? 2'b01 : 2'b00;
          state_d = StDone;
        end else if ((TIMEOUT_CYCLES != 0) && (timer_q == TimerLast)) begin
          error_d = 2'b10;
          state_d = StDone;
        end
      end
      StDone: begin
        if ((error_q != 2'b00) && (errcnt_q != '1)) errcnt_d = errcnt_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cmd_q    <= '0;
      iaddr_q  <= '0;
      daddr_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      error_q  <= '0;
      inst_q   <= '0;
      data_q   <= '0;
      errcnt_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      iaddr_q  <= iaddr_d;
      daddr_q  <= daddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      error_q  <= error_d;
      inst_q   <= inst_d;
      data_q   <= data_d;
      errcnt_q <= errcnt_d;
      timer_q  <= timer_d;
    end
  end

  assign cpu_ready      = (state_q == StIdle);
  assign mem_req_valid  = (state_q == StIssue);
  assign cpu_error      = error_q;
  assign cpu_inst_rdata = inst_q;
  assign cpu_data_rdata = data_q;
  assign mem_command    = cmd_q;
  assign mem_inst_addr  = iaddr_q;
  assign mem_data_addr  = daddr_q;
  assign mem_wdata      = wdata_q;
  assign mem_wstrb      = wstrb_q;
  assign err_count      = errcnt_q;

endmodule

// File: tb/tb_agp32_mem_bridge.sv
// Bench for agp32_mem_bridge: directed scenarios plus random transactions, checked every cycle
// against a transaction-timeline model of the expected outputs.
module tb_agp32_mem_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int AB = 2;
  localparam int TO = 4;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    cpu_command;
  logic [AW-1:0] cpu_inst_addr, cpu_data_addr;
  logic [DW-1:0] cpu_wdata;
  logic [3:0]    cpu_wstrb;
  logic          cpu_ready;
  logic [1:0]    cpu_error;
  logic [DW-1:0] cpu_inst_rdata, cpu_data_rdata;
  logic          mem_req_valid, mem_req_accept;
  logic [2:0]    mem_command;
  logic [AW-1:0] mem_inst_addr, mem_data_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_resp_valid, mem_resp_error;
  logic [DW-1:0] mem_inst_rdata, mem_data_rdata;
  logic [EW-1:0] err_count;

  agp32_mem_bridge #(
    .ADDR_W(AW), .DATA_W(DW), .ALIGN_BITS(AB), .STRICT_ALIGN(1),
    .TIMEOUT_CYCLES(TO), .ERRCNT_W(EW)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_command(cpu_command), .cpu_inst_addr(cpu_inst_addr), .cpu_data_addr(cpu_data_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready), .cpu_error(cpu_error),
    .cpu_inst_rdata(cpu_inst_rdata), .cpu_data_rdata(cpu_data_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_accept(mem_req_accept), .mem_command(mem_command),
    .mem_inst_addr(mem_inst_addr), .mem_data_addr(mem_data_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_resp_valid(mem_resp_valid), .mem_resp_error(mem_resp_error),
    .mem_inst_rdata(mem_inst_rdata), .mem_data_rdata(mem_data_rdata), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Expected outputs, updated 1ns after each rising edge, compared on the falling edge.
  logic          exp_ready, exp_valid;
  logic [1:0]    exp_error;
  logic [DW-1:0] exp_inst, exp_data, exp_wd;
  logic [EW-1:0] exp_cnt;
  logic [2:0]    exp_cmd;
  logic [AW-1:0] exp_ia, exp_da;
  logic [3:0]    exp_ws;

  int vectors = 0;
  int miscompares = 0;
  int req_count = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cpu_ready", 64'(cpu_ready), 64'(exp_ready));
      chk("mem_req_valid", 64'(mem_req_valid), 64'(exp_valid));
      chk("cpu_error", 64'(cpu_error), 64'(exp_error));
      chk("cpu_inst_rdata", 64'(cpu_inst_rdata), 64'(exp_inst));
      chk("cpu_data_rdata", 64'(cpu_data_rdata), 64'(exp_data));
      chk("err_count", 64'(err_count), 64'(exp_cnt));
      chk("mem_command", 64'(mem_command), 64'(exp_cmd));
      chk("mem_inst_addr", 64'(mem_inst_addr), 64'(exp_ia));
      chk("mem_data_addr", 64'(mem_data_addr), 64'(exp_da));
      chk("mem_wdata", 64'(mem_wdata), 64'(exp_wd));
      chk("mem_wstrb", 64'(mem_wstrb), 64'(exp_ws));
    end
  end

  always @(posedge clk) if (mem_req_valid && mem_req_accept) req_count++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    return a - (a % (AW'(1) << AB));
  endfunction

  task automatic set_reset_exp();
    exp_ready = 1'b1; exp_valid = 1'b0; exp_error = 2'b00;
    exp_inst = '0; exp_data = '0; exp_cnt = '0; exp_cmd = '0;
    exp_ia = '0; exp_da = '0; exp_wd = '0; exp_ws = '0;
  endtask

  task automatic junk_resp();
    mem_inst_rdata = $urandom;
    mem_data_rdata = $urandom;
    mem_resp_error = 1'($urandom % 2);
  endtask

  task automatic junk_cpu(input bit busy);
    cpu_command   = busy ? 3'($urandom_range(1, 5)) : 3'($urandom_range(5, 8) % 8);
    if (!busy && cpu_command == 3'd5) cpu_command = 3'd0;
    cpu_inst_addr = $urandom;
    cpu_data_addr = $urandom;
    cpu_wdata     = $urandom;
    cpu_wstrb     = 4'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      junk_cpu(1'b0);
      mem_req_accept = 1'($urandom % 2);
      mem_resp_valid = 1'($urandom % 2);
      junk_resp();
      tick();
    end
  endtask

  task automatic run_txn(input logic [2:0] cmd, input logic [AW-1:0] ia, input logic [AW-1:0] da,
                         input logic [DW-1:0] wd, input logic [3:0] ws, input int acc_dly,
                         input int resp_dly, input bit rerr, input logic [DW-1:0] ri,
                         input logic [DW-1:0] rd);
    bit reject;
    bit done;
    int c;
    cpu_command = cmd; cpu_inst_addr = ia; cpu_data_addr = da; cpu_wdata = wd; cpu_wstrb = ws;
    mem_req_accept = 1'b0;
    tick();
    exp_ready = 1'b0; exp_error = 2'b00; exp_cmd = cmd;
    exp_ia = align(ia); exp_da = align(da); exp_wd = wd; exp_ws = ws;
    reject = (cmd == 3'd3 || cmd == 3'd5) && (da % 4 != 0);
    junk_cpu(1'b1);
    if (reject) begin
      exp_error = 2'b11;
    end else begin
      exp_valid = 1'b1;
      repeat (acc_dly) begin
        mem_resp_valid = 1'($urandom % 2);
        junk_resp();
        tick();
      end
      mem_req_accept = 1'b1;
      tick();
      mem_req_accept = 1'b0;
      exp_valid = 1'b0;
      done = 1'b0;
      for (int i = 0; !done; i++) begin
        if (i == resp_dly) begin
          mem_resp_valid = 1'b1; mem_resp_error = rerr;
          mem_inst_rdata = ri; mem_data_rdata = rd;
          tick();
          exp_error = rerr ? 2'b01 : 2'b00;
          if (cmd inside {3'd1, 3'd4, 3'd5}) exp_inst = ri;
          if (cmd inside {3'd2, 3'd4}) exp_data = rd;
          done = 1'b1;
        end else begin
          mem_resp_valid = 1'b0;
          junk_resp();
          tick();
          if (i == TO - 1) begin
            exp_error = 2'b10;
            done = 1'b1;
          end
        end
      end
    end
    // Completion cycle: a stray response here must be ignored.
    mem_resp_valid = 1'b1;
    junk_resp();
    tick();
    exp_ready = 1'b1;
    if (exp_error != 2'b00) begin
      c = int'(exp_cnt) + 1;
      if (c > (1 << EW) - 1) c = (1 << EW) - 1;
      exp_cnt = EW'(c);
    end
    cpu_command = 3'd0;
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    int rc;
    int cnt_lit [5];
    logic [2:0] rcmd;
    logic [AW-1:0] rda;
    cnt_lit = '{1, 2, 3, 3, 3};
    rst = 1'b1;
    cpu_command = '0; cpu_inst_addr = '0; cpu_data_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    mem_req_accept = 1'b0; mem_resp_valid = 1'b0; mem_resp_error = 1'b0;
    mem_inst_rdata = '0; mem_data_rdata = '0;
    set_reset_exp();
    chk_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_ready", 64'(cpu_ready), 64'd1);
    chk("reset_err_count", 64'(err_count), 64'd0);
    idle(2);

    // Aligned read with a response on the second wait cycle.
    run_txn(3'd2, 32'h0, 32'h1003, 32'h0, 4'h0, 0, 1, 1'b0, 32'h1111_2222, 32'hDEAD_BEEF);
    chk("t1_data_addr", 64'(mem_data_addr), 64'h1000);
    chk("t1_data_rdata", 64'(cpu_data_rdata), 64'hDEAD_BEEF);
    chk("t1_error", 64'(cpu_error), 64'd0);
    chk("t1_ready", 64'(cpu_ready), 64'd1);

    // Misaligned fetch+write is rejected without a memory request.
    rc = req_count;
    run_txn(3'd5, 32'h40, 32'h22, 32'h5555_AAAA, 4'hF, 0, 0, 1'b0, 32'h0, 32'h0);
    chk("t2_error", 64'(cpu_error), 64'd3);
    chk("t2_err_count", 64'(err_count), 64'd1);
    chk("t2_no_request", 64'(req_count - rc), 64'd0);

    // Fetch with memory stalling acceptance for 10 cycles.
    rc = req_count;
    run_txn(3'd1, 32'h107, 32'h0, 32'h0, 4'h0, 10, 0, 1'b0, 32'hCAFE_0001, 32'h0);
    chk("t3_single_request", 64'(req_count - rc), 64'd1);
    chk("t3_inst_addr", 64'(mem_inst_addr), 64'h104);
    chk("t3_inst_rdata", 64'(cpu_inst_rdata), 64'hCAFE_0001);

    // Read that never gets a response times out; later responses change nothing.
    run_txn(3'd2, 32'h0, 32'h2000, 32'h0, 4'h0, 0, 99, 1'b0, 32'h0, 32'h0);
    chk("t4_error", 64'(cpu_error), 64'd2);
    chk("t4_err_count", 64'(err_count), 64'd2);
    idle(3);
    chk("t4_data_kept", 64'(cpu_data_rdata), 64'hDEAD_BEEF);

    // Asynchronous reset in the middle of a wait.
    cpu_command = 3'd2; cpu_data_addr = 32'h3004;
    tick();
    exp_ready = 1'b0; exp_valid = 1'b1; exp_cmd = 3'd2; exp_error = 2'b00;
    exp_ia = align(cpu_inst_addr); exp_da = 32'h3004; exp_wd = cpu_wdata; exp_ws = cpu_wstrb;
    cpu_command = 3'd0; mem_req_accept = 1'b1;
    tick();
    exp_valid = 1'b0; mem_req_accept = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    set_reset_exp();
    tick();
    chk("t6_ready_in_reset", 64'(cpu_ready), 64'd1);
    chk("t6_err_count_reset", 64'(err_count), 64'd0);
    chk("t6_addr_reset", 64'(mem_data_addr), 64'd0);
    tick();
    rst = 1'b0;
    run_txn(3'd2, 32'h0, 32'h3008, 32'h0, 4'h0, 1, 2, 1'b0, 32'h0, 32'h1234_5678);
    chk("t6_after_reset_data", 64'(cpu_data_rdata), 64'h1234_5678);
    chk("t6_after_reset_error", 64'(cpu_error), 64'd0);

    // Saturating error counter.
    for (int k = 0; k < 5; k++) begin
      run_txn(3'd2, 32'h0, 32'h4000, 32'h0, 4'h0, 0, 0, 1'b1, 32'h0, 32'h0);
      chk("t5_err_count", 64'(err_count), 64'(cnt_lit[k]));
    end

    // Random transactions.
    repeat (200) begin
      idle($urandom_range(0, 2));
      rcmd = 3'($urandom_range(1, 5));
      rda = $urandom;
      if ($urandom % 2 == 0) rda[1:0] = 2'b00;
      run_txn(rcmd, $urandom, rda, $urandom, 4'($urandom), $urandom_range(0, 3),
              $urandom_range(0, 5), 1'($urandom % 4 == 0), $urandom, $urandom);
    end
    idle(2);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
